// File: rtl/uart_input.sv
// uart_input: 8N1 serial receiver (LSB first) with a one-entry holding
// register, valid/ready hand-off, and sticky framing/overrun flags.
module uart_input #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       err_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  // Last count of a full bit period and of the half period used to
  // reach mid-start-bit.
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_busy;
  logic            r_frame_err;
  logic            r_overrun;

  logic            w_rx_s;
  logic            w_half_tick;
  logic            w_bit_tick;
  logic            w_data_sample;
  logic            w_stop_sample;
  logic            w_deliver;
  logic            w_bad_stop;
  logic            w_accept;
  logic            w_drop;

  assign w_rx_s        = r_sync2;
  assign w_half_tick   = (r_cnt == HALF);
  assign w_bit_tick    = (r_cnt == FULL);
  assign w_data_sample = (r_state == S_DATA) && w_bit_tick;
  assign w_stop_sample = (r_state == S_STOP) && w_bit_tick;
  assign w_deliver     = w_stop_sample && w_rx_s;
  assign w_bad_stop    = w_stop_sample && !w_rx_s;
  // Holding register can take a new byte if empty or being drained now.
  assign w_accept      = !r_valid || rx_ready;
  assign w_drop        = w_deliver && !w_accept;

  // Two-flop synchronizer; line idles high so reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (!w_rx_s) w_next = S_START;
      S_START:     if (w_half_tick) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (w_bit_tick && (r_bit == 3'd7)) w_next = S_STOP;
      S_STOP:      if (w_bit_tick) w_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx_s) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Cycle and bit counters; the cycle counter wraps on every sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      unique case (r_state)
        S_START: begin
          r_bit <= '0;
          if (w_half_tick) r_cnt <= '0;
          else             r_cnt <= r_cnt + CW'(1);
        end
        S_DATA: begin
          if (w_bit_tick) begin
            r_cnt <= '0;
            r_bit <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_tick) r_cnt <= '0;
          else            r_cnt <= r_cnt + CW'(1);
        end
        default: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
      endcase
    end
  end

  // Shift register: right shift so the first (LSB) bit ends in bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_shift <= 8'h00;
    else if (w_data_sample) r_shift <= {w_rx_s, r_shift[7:1]};
  end

  // Holding register and valid/ready hand-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_deliver && w_accept) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
    end else if (r_valid && rx_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky flags: a set event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_bad_stop)     r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
      if (w_drop)         r_overrun   <= 1'b1;
      else if (err_clear) r_overrun   <= 1'b0;
    end
  end

  // Busy tracks the state register exactly, including WAIT_HIGH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= 1'b0;
    else       r_busy <= (w_next != S_IDLE);
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign rx_busy     = r_busy;
  assign frame_error = r_frame_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_input.sv
// tb_uart_input: drives 8N1 frames into uart_input and checks bytes, flags,
// latency and hand-off against a queue-based reference of what was sent.
module tb_uart_input;

  localparam int C = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic       err_clear;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun;

  int n_tests;
  int n_fail;
  int valid_cycles;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_input #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_ready(rx_ready),
    .err_clear(err_clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .frame_error(frame_error), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer-side monitor: every accepted byte is recorded.
  always @(negedge clk) begin
    if (!reset && rx_valid) begin
      valid_cycles++;
      if (rx_ready) got_q.push_back(rx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: start, 8 data bits LSB first, stop; each bit C cycles.
  // The line is left at the stop-bit value.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [7:0] b;
    b = d;
    @(negedge clk); rx = 1'b0; cyc(C - 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx = b[i]; cyc(C - 1);
    end
    @(negedge clk); rx = stop; cyc(C - 1);
  endtask

  initial begin
    int lat;
    bit seen;
    int k;
    logic [7:0] d;
    logic [7:0] first;
    logic stop;
    logic exp_fe;
    logic [7:0] b99;

    n_tests = 0; n_fail = 0; valid_cycles = 0;
    reset = 1'b1; rx = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
    cyc(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_busy", rx_busy, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_ov", overrun, 0);
    reset = 1'b0;
    cyc(4);

    // Single byte with latency measurement from the first edge seeing rx low.
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(negedge clk);
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (rx_valid) begin lat = i; break; end
          @(posedge clk);
        end
      end
    join
    chk("latency_in_window", (lat >= 152 + 2) && (lat <= 152 + 4), 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_fe", frame_error, 0);
    chk("a5_ov", overrun, 0);
    rx_ready = 1'b1; cyc(1); rx_ready = 1'b0;
    chk("a5_consumed", rx_valid, 0);
    cyc(2);
    got_q.delete();

    // Back-to-back frames with the consumer always ready.
    rx_ready = 1'b1; valid_cycles = 0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    cyc(30);
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first", got_q[0], 8'h00);
      chk("b2b_second", got_q[1], 8'hFF);
    end
    chk("b2b_pulse_cycles", valid_cycles, 2);
    chk("b2b_fe", frame_error, 0);
    chk("b2b_ov", overrun, 0);
    rx_ready = 1'b0;
    got_q.delete();

    // Short low glitch: aborted in START, no byte, busy drops.
    valid_cycles = 0; seen = 0;
    @(negedge clk); rx = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (rx_busy) seen = 1; end
    rx = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rx_busy) seen = 1; end
    chk("glitch_busy_seen", seen, 1);
    cyc(8);
    chk("glitch_busy_gone", rx_busy, 0);
    chk("glitch_no_valid", valid_cycles, 0);
    chk("glitch_fe", frame_error, 0);

    // Bad stop bit followed by a break.
    send_frame(8'h3C, 1'b0);
    cyc(40);
    chk("brk_fe", frame_error, 1);
    chk("brk_valid", rx_valid, 0);
    chk("brk_busy", rx_busy, 1);
    rx = 1'b1; cyc(5);
    send_frame(8'h55, 1'b1);
    cyc(20);
    chk("brk_next_data", rx_data, 8'h55);
    chk("brk_next_valid", rx_valid, 1);
    err_clear = 1'b1; cyc(1); err_clear = 1'b0;
    chk("brk_fe_cleared", frame_error, 0);
    rx_ready = 1'b1; cyc(1); rx_ready = 1'b0;
    cyc(2);
    got_q.delete();

    // Overrun, then a clear held across a third overrun: set wins.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    cyc(20);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", overrun, 1);
    err_clear = 1'b1; cyc(1);
    chk("ovr_cleared", overrun, 0);
    seen = 0;
    fork
      send_frame(8'h33, 1'b1);
      begin
        for (int i = 0; i < 220; i++) begin
          @(negedge clk);
          if (overrun) begin seen = 1; err_clear = 1'b0; break; end
        end
        err_clear = 1'b0;
      end
    join
    chk("ovr_set_beats_clear", seen, 1);
    cyc(3);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_data_kept", rx_data, 8'h11);

    // Reset in the middle of data bit 4.
    b99 = 8'h99;
    @(negedge clk); rx = 1'b0; cyc(C - 1);
    for (int i = 0; i < 4; i++) begin @(negedge clk); rx = b99[i]; cyc(C - 1); end
    @(negedge clk); rx = b99[4]; cyc(8);
    chk("mid_busy", rx_busy, 1);
    reset = 1'b1; #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_busy", rx_busy, 0);
    chk("mid_rst_flags", {frame_error, overrun}, 2'b00);
    rx = 1'b1; cyc(3); reset = 1'b0; cyc(3);
    send_frame(8'h7E, 1'b1);
    cyc(20);
    chk("post_rst_data", rx_data, 8'h7E);
    chk("post_rst_valid", rx_valid, 1);
    chk("post_rst_flags", {frame_error, overrun}, 2'b00);
    rx_ready = 1'b1; cyc(2);
    got_q.delete();

    // Random frames, consumer ready; reference is the list of good frames.
    exp_q.delete(); exp_fe = 1'b0;
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      if (stop) exp_q.push_back(d);
      else      exp_fe = 1'b1;
      rx = 1'b1;
      cyc(2 + $urandom_range(0, 10));
    end
    cyc(30);
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_byte%0d", i), got_q[i], exp_q[i]);
    chk("rnd_fe", frame_error, exp_fe);
    chk("rnd_ov", overrun, 0);

    // Random burst with consumer stalled: first byte held, rest dropped.
    rx_ready = 1'b0; err_clear = 1'b1; cyc(1); err_clear = 1'b0;
    k = $urandom_range(1, 3);
    first = 8'h00;
    for (int n = 0; n < k; n++) begin
      d = 8'($urandom_range(0, 255));
      if (n == 0) first = d;
      send_frame(d, 1'b1);
      cyc($urandom_range(0, 5));
    end
    cyc(20);
    chk("stall_data", rx_data, first);
    chk("stall_valid", rx_valid, 1);
    chk("stall_ov", overrun, (k > 1) ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_input.md
Name: uart_input

Overview:
Serial UART receiver (8N1, LSB first) that turns an asynchronous line into bytes for the accumulator processor's input path. It is the receive-side counterpart of the simulation UART output. Received bytes sit in a one-entry holding register and are handed over with a valid/ready handshake. Framing errors and overruns are reported as sticky flags.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit. Must be even and >= 4.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line; idles high; asynchronous to clk
rx_ready  input  1  consumer accepts the held byte this cycle
err_clear  input  1  clears frame_error and overrun
rx_data  output  8  held byte
rx_valid  output  1  rx_data holds an unconsumed byte
rx_busy  output  1  a frame is in progress (state != IDLE)
frame_error  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: completed byte dropped because the holding register was full

Behaviour:
- Reset (async, active-high): state IDLE; both synchronizer flops = 1; bit counter and cycle counter = 0; shift register = 0x00; rx_data = 0x00; rx_valid, rx_busy, frame_error, overrun = 0. Reset asserted mid-frame aborts the frame with no partial output.
- Input sync: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s == 0, clear the cycle counter and go to START.
  - START: count CLKS_PER_BIT/2 cycles, then sample rx_s. If it is 1 (glitch), return to IDLE with no flags set. If it is 0, clear the counters and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first (bit i lands in position i). After the 8th sample go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If it is 1, deliver the byte and go to IDLE.
    - If it is 0, set frame_error, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition from retriggering.
- Cycle counter: wide enough for CLKS_PER_BIT-1. It wraps to 0 on each sample. Sampling is therefore at mid-bit, nominally.
- Delivery: on the edge after a good stop-bit sample:
  - rx_valid == 0: rx_data <= byte, rx_valid <= 1.
  - rx_valid == 1 and rx_ready == 1 in the same cycle: rx_data <= new byte, rx_valid stays 1, no overrun.
  - rx_valid == 1 and rx_ready == 0: new byte dropped, rx_data unchanged, overrun <= 1.
- Handshake:
  - If rx_valid && rx_ready at an edge with no delivery in that cycle, rx_valid <= 0.
  - rx_data is stable while rx_valid == 1.
  - rx_ready while rx_valid == 0 has no effect.
- Latency: the first clk edge seeing rx low is t0. rx_valid rises within [t0 + 9.5*CLKS_PER_BIT + 2, t0 + 9.5*CLKS_PER_BIT + 4].
- Flags:
  - err_clear clears frame_error and overrun on the next edge.
  - A set event in the same cycle as err_clear wins, so the flag stays 1.
  - Flags never affect rx_valid or rx_data.
- rx_busy is registered and equals (state != IDLE). This includes WAIT_HIGH.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 with rx_ready low -> rx_valid=1, rx_data=0xA5 within the latency window; frame_error=0, overrun=0. Then pulse rx_ready for 1 cycle -> rx_valid=0 on the next edge.
- Send 0x00 then 0xFF back to back (single stop bit), rx_ready held high -> two one-cycle rx_valid pulses carrying 0x00 then 0xFF; no flags.
- Drive rx low for 4 cycles, then high -> enters START, returns to IDLE; no rx_valid; rx_busy=0 within 8 cycles after 8+2 cycles.
- Send 0x3C with stop bit = 0, then hold rx low for 40 cycles -> frame_error=1, rx_valid stays 0, rx_busy stays 1. Release the line, send 0x55 -> rx_data=0x55. Pulse err_clear -> frame_error=0.
- Send 0x11 then 0x22, rx_ready low -> rx_data=0x11, overrun=1. Assert err_clear on the same cycle as a third byte's overrun -> overrun stays 1.
- Assert reset mid-DATA (bit 4 of 0x99) -> all outputs 0, rx_busy=0 immediately. After release, send 0x7E -> rx_data=0x7E, flags 0.
